// File: rtl/uart_cmd_parser_pkg.sv
// Shared definitions for the UART command frame parser and the future TX response framer.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GET_CMD,
    GET_ADDR,
    GET_DATA,
    GET_CHK,
    ISSUE
  } state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Byte positions within a 5-byte frame.
  localparam int IDX_SYNC  = 0;
  localparam int IDX_CMD   = 1;
  localparam int IDX_ADDR  = 2;
  localparam int IDX_DATA  = 3;
  localparam int IDX_CHK   = 4;
  localparam int FRAME_LEN = 5;

  function automatic logic [7:0] frame_checksum(input logic [7:0] code,
                                                input logic [7:0] addr,
                                                input logic [7:0] data);
    return code ^ addr ^ data;
  endfunction

endpackage

// File: rtl/uart_cmd_parser_timeout.sv
// Inter-byte watchdog: counts idle cycles while enabled, clears on activity,
// and flags expiry in the cycle the count reaches LIMIT-1 without a clear.
module uart_cmd_timeout
  import uart_cmd_pkg::*;
#(
  parameter int LIMIT = 65536
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic expire
);

  localparam int CNT_W = $clog2(LIMIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count_reg;

  assign expire = enable && !clear && (count_reg == LAST);

  // Restart from zero after expiry so a fresh frame gets the full window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (!enable || clear || expire) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Sequences UART bytes into SYNC/CMD/ADDR/DATA/CHK frames and hands good ones downstream.
// Define UART_CMD_TIMEOUT_EN to enable the inter-byte timeout watchdog.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE,
  parameter int         TIMEOUT_CLKS = 65536,
  parameter int         ERR_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [7:0]       cmd_code,
  output logic [7:0]       cmd_addr,
  output logic [7:0]       cmd_data,
  output logic             err_chk,
  output logic             err_timeout,
  output logic             err_overrun,
  output logic [ERR_W-1:0] err_count
);

  state_t state_reg;
  logic   expire;
  logic   err_any;

`ifdef UART_CMD_TIMEOUT_EN
  logic in_frame;
  logic timeout_pulse_reg;

  assign in_frame = (state_reg == GET_CMD) || (state_reg == GET_ADDR) ||
                    (state_reg == GET_DATA) || (state_reg == GET_CHK);

  uart_cmd_timeout #(
    .LIMIT(TIMEOUT_CLKS)
  ) u_timeout (
    .clk   (clk),
    .rst_n (rst_n),
    .enable(in_frame),
    .clear (rx_valid),
    .expire(expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_pulse_reg <= 1'b0;
    end else begin
      timeout_pulse_reg <= expire;
    end
  end

  assign err_timeout = timeout_pulse_reg;
`else
  assign expire      = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cmd_valid   <= 1'b0;
      cmd_code    <= 8'h00;
      cmd_addr    <= 8'h00;
      cmd_data    <= 8'h00;
      err_chk     <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      err_chk     <= 1'b0;
      err_overrun <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (rx_valid && (rx_data == SYNC_BYTE)) begin
            state_reg <= GET_CMD;
          end
        end
        GET_CMD: begin
          if (rx_valid) begin
            cmd_code  <= rx_data;
            state_reg <= GET_ADDR;
          end else if (expire) begin
            state_reg <= IDLE;
          end
        end
        GET_ADDR: begin
          if (rx_valid) begin
            cmd_addr  <= rx_data;
            state_reg <= GET_DATA;
          end else if (expire) begin
            state_reg <= IDLE;
          end
        end
        GET_DATA: begin
          if (rx_valid) begin
            cmd_data  <= rx_data;
            state_reg <= GET_CHK;
          end else if (expire) begin
            state_reg <= IDLE;
          end
        end
        GET_CHK: begin
          if (rx_valid) begin
            if (rx_data == frame_checksum(cmd_code, cmd_addr, cmd_data)) begin
              cmd_valid <= 1'b1;
              state_reg <= ISSUE;
            end else begin
              err_chk   <= 1'b1;
              state_reg <= IDLE;
            end
          end else if (expire) begin
            state_reg <= IDLE;
          end
        end
        ISSUE: begin
          // A byte arriving with the handshake is treated as the first IDLE byte.
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            if (rx_valid && (rx_data == SYNC_BYTE)) begin
              state_reg <= GET_CMD;
            end else begin
              state_reg <= IDLE;
            end
          end else if (rx_valid) begin
            err_overrun <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          cmd_valid <= 1'b0;
        end
      endcase
    end
  end

  assign err_any = err_chk || err_timeout || err_overrun;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (err_any && (err_count != {ERR_W{1'b1}})) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed self-checking bench for uart_cmd_parser; a second ERR_W=2 instance covers saturation.
module tb_uart_cmd_parser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       cmd_ready = 1'b0;

  logic       cmd_valid;
  logic [7:0] cmd_code, cmd_addr, cmd_data;
  logic       err_chk, err_timeout, err_overrun;
  logic [7:0] err_count;

  logic       s_cmd_valid;
  logic [7:0] s_cmd_code, s_cmd_addr, s_cmd_data;
  logic       s_err_chk, s_err_timeout, s_err_overrun;
  logic [1:0] s_err_count;

  int n_vec = 0;
  int n_miss = 0;
  int n_cv, n_chk, n_to, n_ov;

  always #5 clk = ~clk;

  uart_cmd_parser #(
    .TIMEOUT_CLKS(16),
    .ERR_W       (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_code   (cmd_code),
    .cmd_addr   (cmd_addr),
    .cmd_data   (cmd_data),
    .err_chk    (err_chk),
    .err_timeout(err_timeout),
    .err_overrun(err_overrun),
    .err_count  (err_count)
  );

  uart_cmd_parser #(
    .TIMEOUT_CLKS(16),
    .ERR_W       (2)
  ) dut_sat (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .cmd_valid  (s_cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_code   (s_cmd_code),
    .cmd_addr   (s_cmd_addr),
    .cmd_data   (s_cmd_data),
    .err_chk    (s_err_chk),
    .err_timeout(s_err_timeout),
    .err_overrun(s_err_overrun),
    .err_count  (s_err_count)
  );

  // Cycle counters of pulse-type outputs, sampled at the active edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_cv  <= 0;
      n_chk <= 0;
      n_to  <= 0;
      n_ov  <= 0;
    end else begin
      if (cmd_valid)   n_cv  <= n_cv + 1;
      if (err_chk)     n_chk <= n_chk + 1;
      if (err_timeout) n_to  <= n_to + 1;
      if (err_overrun) n_ov  <= n_ov + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] a,
                            input logic [7:0] d, input logic [7:0] k);
    send_byte(8'hA5);
    send_byte(c);
    send_byte(a);
    send_byte(d);
    send_byte(k);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_fields(input string tag, input logic [7:0] c,
                              input logic [7:0] a, input logic [7:0] d);
    check({tag, " cmd_valid"}, 32'(cmd_valid), 32'd1);
    check({tag, " cmd_code"},  32'(cmd_code),  32'(c));
    check({tag, " cmd_addr"},  32'(cmd_addr),  32'(a));
    check({tag, " cmd_data"},  32'(cmd_data),  32'(d));
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    check("rst cmd_valid", 32'(cmd_valid), 32'd0);
    check("rst cmd_code",  32'(cmd_code),  32'd0);
    check("rst err_count", 32'(err_count), 32'd0);
    check("rst err_chk",   32'(err_chk),   32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Good frame, then two back-to-back frames with cmd_ready held high
    cmd_ready = 1'b1;
    send_frame(8'h57, 8'h10, 8'h3C, 8'h7B);
    check_fields("good", 8'h57, 8'h10, 8'h3C);
    idle(3);
    check("good valid cycles", 32'(n_cv), 32'd1);
    check("good err_count", 32'(err_count), 32'd0);
    send_frame(8'h57, 8'h10, 8'h3C, 8'h7B);
    send_frame(8'h01, 8'h02, 8'h03, 8'h00);
    check_fields("b2b", 8'h01, 8'h02, 8'h03);
    idle(2);
    check("b2b valid cycles", 32'(n_cv), 32'd3);

    // Bad checksum then recovery
    send_frame(8'h57, 8'h10, 8'h3C, 8'h7A);
    check("badchk err_chk", 32'(err_chk), 32'd1);
    check("badchk cmd_valid", 32'(cmd_valid), 32'd0);
    idle(2);
    check("badchk pulses", 32'(n_chk), 32'd1);
    check("badchk err_count", 32'(err_count), 32'd1);
    check("badchk valid cycles", 32'(n_cv), 32'd3);
    send_frame(8'h01, 8'h02, 8'h03, 8'h00);
    check_fields("recover", 8'h01, 8'h02, 8'h03);
    idle(2);

    // Backpressure and overrun
    do_reset();
    cmd_ready = 1'b0;
    send_frame(8'h12, 8'h34, 8'h56, 8'h70);
    check("bp cmd_valid", 32'(cmd_valid), 32'd1);
    send_byte(8'hFF);
    check("bp err_overrun", 32'(err_overrun), 32'd1);
    send_byte(8'hA5);
    idle(2);
    check_fields("bp hold", 8'h12, 8'h34, 8'h56);
    check("bp overruns", 32'(n_ov), 32'd2);
    check("bp err_count", 32'(err_count), 32'd2);
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    check("bp release", 32'(cmd_valid), 32'd0);

    // Handshake and SYNC byte in the same cycle
    do_reset();
    send_frame(8'h57, 8'h10, 8'h3C, 8'h7B);
    idle(1);
    cmd_ready = 1'b1;
    send_byte(8'hA5);
    cmd_ready = 1'b0;
    check("simul cmd_valid", 32'(cmd_valid), 32'd0);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h00);
    check_fields("simul next", 8'h11, 8'h22, 8'h33);
    check("simul overruns", 32'(n_ov), 32'd0);
    check("simul err_count", 32'(err_count), 32'd0);
    cmd_ready = 1'b1;
    idle(1);

    // Mid-frame stall
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h57);
    idle(16);
    idle(2);
`ifdef UART_CMD_TIMEOUT_EN
    check("stall timeouts", 32'(n_to), 32'd1);
    check("stall err_count", 32'(err_count), 32'd1);
    send_frame(8'h01, 8'h02, 8'h03, 8'h00);
    check_fields("after timeout", 8'h01, 8'h02, 8'h03);
`else
    check("stall timeouts", 32'(n_to), 32'd0);
    check("stall err_count", 32'(err_count), 32'd0);
    send_byte(8'h10);
    send_byte(8'h3C);
    send_byte(8'h7B);
    check_fields("stall resume", 8'h57, 8'h10, 8'h3C);
`endif
    idle(2);

    // Saturation and reset mid-frame
    do_reset();
    repeat (2) send_frame(8'h57, 8'h10, 8'h3C, 8'h7A);
    idle(2);
    check("sat2 narrow count", 32'(s_err_count), 32'd2);
    check("sat2 wide count", 32'(err_count), 32'd2);
    repeat (3) send_frame(8'h57, 8'h10, 8'h3C, 8'h7A);
    idle(2);
    check("sat5 narrow count", 32'(s_err_count), 32'd3);
    check("sat5 wide count", 32'(err_count), 32'd5);
    send_byte(8'hA5);
    send_byte(8'h57);
    rst_n = 1'b0;
    #1;
    check("midrst err_count", 32'(err_count), 32'd0);
    check("midrst narrow count", 32'(s_err_count), 32'd0);
    check("midrst cmd_code", 32'(cmd_code), 32'd0);
    check("midrst err_chk", 32'(err_chk), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_byte(8'h10);
    send_byte(8'h3C);
    send_byte(8'h7B);
    idle(2);
    check("midrst no frame", 32'(n_cv), 32'd0);
    check("midrst no chk", 32'(n_chk), 32'd0);
    check("midrst count stays", 32'(err_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
Frame controller that sits directly behind the UART 8-N-1 receiver and sequences its byte stream into fixed 5-byte command frames: SYNC, CMD, ADDR, DATA, CHK.
- Validates the checksum.
- Presents each good frame to the register-bus side with a valid/ready handshake.
- Reports checksum, timeout and overrun errors, and counts them.
- This is the only consumer of the receiver's data/ready outputs.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CLKS, 65536, max clk cycles allowed between bytes inside a frame; legal range is 2 to 2^24.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock
- rst_n  input  1  async active-low reset
- rx_data  input  8  byte from the UART receiver
- rx_valid  input  1  one-clk pulse; rx_data is valid in that cycle
- cmd_valid  output  1  frame available
- cmd_ready  input  1  downstream accepts the frame
- cmd_code  output  8  CMD byte of the frame
- cmd_addr  output  8  ADDR byte of the frame
- cmd_data  output  8  DATA byte of the frame
- err_chk  output  1  one-clk pulse: checksum mismatch
- err_timeout  output  1  one-clk pulse: inter-byte timeout
- err_overrun  output  1  one-clk pulse: byte dropped while a frame is pending
- err_count  output  ERR_W  saturating total of all errors

Behaviour:
- Reset: clk is the clock; rst_n is the asynchronous, active-low reset. While reset is asserted:
  - state=IDLE.
  - All outputs are 0, including cmd_code/addr/data and err_count.
  - The timeout counter is 0.
  - Reset mid-frame discards the partial frame with no error pulse.
- FSM states: IDLE, GET_CMD, GET_ADDR, GET_DATA, GET_CHK, ISSUE. A byte is acted on only in a cycle where rx_valid=1.
- IDLE:
  - rx_data==SYNC_BYTE → GET_CMD.
  - Any other byte is ignored silently, with no error.
- GET_CMD, GET_ADDR, GET_DATA:
  - Each latches its byte into the matching internal register, then advances to the next state.
  - SYNC_BYTE has no special meaning in these states (no resync).
- GET_CHK: the expected value is CMD^ADDR^DATA.
  - On a match: go to ISSUE and assert cmd_valid on the next clk edge, i.e. 1 cycle after the CHK rx_valid.
  - On a mismatch: pulse err_chk for 1 cycle, go to IDLE, leave cmd_valid at 0.
- ISSUE:
  - cmd_valid and cmd_code/addr/data are held stable until cmd_valid&&cmd_ready.
  - The handshake clears cmd_valid on the next edge and returns to IDLE.
  - cmd_ready is ignored when cmd_valid=0.
- ISSUE with rx_valid and cmd_ready=0: the byte is dropped, err_overrun pulses, and the state is unchanged.
- ISSUE with rx_valid and cmd_ready=1 in the same cycle: the handshake completes, the byte is not counted as an overrun, and it is evaluated as an IDLE byte. A SYNC_BYTE therefore goes directly to GET_CMD.
- err_count:
  - Increments by 1 per error-pulse cycle; at most one error can occur per cycle.
  - Saturates at 2^ERR_W-1 and never wraps.
- Throughput: back-to-back frames with zero idle clocks between bytes must be accepted when cmd_ready is held at 1.

Optional Feature:
- Macro: UART_CMD_TIMEOUT_EN.
- Defined:
  - In states GET_CMD through GET_CHK, a counter clears on every rx_valid and increments otherwise.
  - On reaching TIMEOUT_CLKS-1 with no rx_valid: err_timeout pulses, the state goes to IDLE and the partial frame is discarded.
  - rx_valid in the same cycle as expiry: the byte wins, is processed normally, and the counter clears.
  - The counter is idle (held at 0) in IDLE and ISSUE.
- Not defined:
  - There is no counter logic; the parser waits indefinitely mid-frame.
  - err_timeout is tied to 0.

Decomposition:
- Package uart_cmd_pkg holds:
  - the state enum;
  - the default SYNC_BYTE constant;
  - the frame byte-index constants;
  - a checksum function, shared with the future TX response framer.
- One natural sub-module, uart_cmd_timeout: a counter with clear, enable and expire outputs, instantiated only under UART_CMD_TIMEOUT_EN.

Test Plan:
- Good frame: bytes A5 57 10 3C 7B with cmd_ready=1. Required: cmd_valid high exactly 1 cycle, 1 clk after the 7B byte, with cmd_code=57, addr=10, data=3C; err_count=0.
- Bad checksum: A5 57 10 3C 7A. Required: err_chk 1-cycle pulse, no cmd_valid, err_count=1. The following frame A5 01 02 03 00 is then accepted.
- Backpressure/overrun: good frame with cmd_ready=0, then 2 more bytes. Required: cmd_valid and fields stay stable, err_overrun pulses twice, err_count=2. Raising cmd_ready for 1 cycle clears cmd_valid.
- Simultaneous: cmd_ready=1 and rx_valid=A5 in the same cycle while in ISSUE. Required: handshake completes, no overrun. The next frame 11 22 33 00 is accepted (checksum 11^22^33=00).
- Timeout (macro defined, TIMEOUT_CLKS=16): send A5 57 then stall for 16 clks. Required: err_timeout pulses once, and A5 01 02 03 00 is then decoded correctly. Without the macro, the same stall gives no pulse, and 10 3C 7B completes the frame.
- Saturation (ERR_W=2): 5 bad-checksum frames → err_count=3. Assert rst_n low mid-frame → everything returns to 0 immediately, with no error pulse.
